// File: rtl/fifo_rd_stream.sv
// Read-side stream stage for the async FIFO: first word appears 2 clks after the first pop and then 1 word/clk.
// Two-entry skid buffer with credit-gated popping, so a stalled consumer freezes out_data and nothing is lost.
module fifo_rd_stream #(
  parameter int DATASIZE = 8
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic [DATASIZE-1:0] rdata,
  output logic                rinc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATASIZE-1:0] out_data,
  output logic [1:0]          out_level
);

  logic [DATASIZE-1:0] buf0;
  logic [DATASIZE-1:0] buf1;
  logic [1:0]          cnt;
  logic                infl;
  logic                pop;
  logic [2:0]          credit;

  assign pop    = (cnt != 2'd0) & out_ready;
  // pop only happens with cnt >= 1, so the subtraction never wraps
  assign credit = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
  assign rinc   = rrst_n & ~flush & ~rempty & (credit < 3'd2);

  assign out_valid = (cnt != 2'd0);
  assign out_data  = buf0;
  assign out_level = cnt;

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      buf0 <= '0;
      buf1 <= '0;
      cnt  <= 2'd0;
      infl <= 1'b0;
    end else if (flush) begin
      cnt  <= 2'd0;
      infl <= 1'b0;
    end else begin
      infl <= rinc;
      if (pop) begin
        if (infl) begin
          if (cnt == 2'd1) begin
            buf0 <= rdata;
          end else begin
            buf0 <= buf1;
            buf1 <= rdata;
          end
        end else begin
          buf0 <= buf1;
          cnt  <= cnt - 2'd1;
        end
      end else if (infl) begin
        if (cnt == 2'd0) begin
          buf0 <= rdata;
        end else begin
          buf1 <= rdata;
        end
        cnt <= cnt + 2'd1;
      end
    end
  end

  // The credit check must make an arrival into a full, non-draining buffer unreachable
  always @(posedge rclk) begin
    if (rrst_n && !flush) begin
      assert (!(infl && !pop && cnt == 2'd2));
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO with registered read, vector table plus corner sequences.
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'hEE;
  logic       rinc;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic [1:0] out_level;

  fifo_rd_stream #(.DATASIZE(8)) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_level (out_level)
  );

  always #5 rclk = ~rclk;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       rdy;
    logic       e_rinc;
    logic       e_vld;
    logic       chk_dat;
    logic [7:0] e_dat;
    logic [1:0] e_lvl;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] q   [$];
  logic [7:0] exq [$];

  int checks = 0;
  int passes = 0;
  int cyc_no = 0;
  int acc_cnt = 0;
  int first_acc = -1;
  int last_acc = -1;
  int last_word = -1;
  int bad_rinc = 0;
  int bad_credit = 0;
  int pulses = 0;
  int unstable = 0;
  int base = 0;
  logic infl_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, exp, cyc_no);
  endtask

  task automatic load(input logic [7:0] w);
    q.push_back(w);
    exq.push_back(w);
    rempty = 1'b0;
  endtask

  // One clock: sample at negedge+1, scoreboard handshakes, then model the registered memory read.
  task automatic cyc();
    logic r;
    int   e;
    #1;
    r = rinc;
    pulses += int'(r);
    if (rinc && rempty) bad_rinc++;
    if (int'(out_level) + int'(infl_prev) > 2) bad_credit++;
    if (out_valid && out_ready) begin
      e = -1;
      if (exq.size() > 0) e = int'(exq.pop_front());
      chk("sb_word", int'(out_data), e);
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc_no;
      last_acc  = cyc_no;
      last_word = int'(out_data);
    end
    @(posedge rclk);
    #1;
    infl_prev = r;
    if (r) rdata = q.pop_front();
    else   rdata = 8'hEE;
    rempty = (q.size() == 0);
    cyc_no++;
    @(negedge rclk);
  endtask

  initial begin
    //         rst   fl    rdy   rinc  vld   cdat  dat    lvl
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 2'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 2'd1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h33, 2'd1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0};

    // reset with a non-empty FIFO, then fill latency and streaming of three words
    load(8'h11); load(8'h22); load(8'h33);
    rrst_n = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) begin
      rrst_n    = tbl[i].rst;
      flush     = tbl[i].fl;
      out_ready = tbl[i].rdy;
      #1;
      chk($sformatf("v%0d_rinc", i), int'(rinc), int'(tbl[i].e_rinc));
      chk($sformatf("v%0d_valid", i), int'(out_valid), int'(tbl[i].e_vld));
      chk($sformatf("v%0d_level", i), int'(out_level), int'(tbl[i].e_lvl));
      if (tbl[i].chk_dat) chk($sformatf("v%0d_data", i), int'(out_data), int'(tbl[i].e_dat));
      cyc();
    end

    // back-pressure: 8 queued, consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) load(8'h40 + 8'(i));
    pulses = 0;
    unstable = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i >= 1 && !(out_valid && out_data == 8'h40)) unstable++;
    end
    chk("bp_rinc_pulses", pulses, 2);
    chk("bp_level", int'(out_level), 2);
    chk("bp_head", int'(out_data), 8'h40);
    chk("bp_stall_stable", unstable, 0);
    out_ready = 1'b1;
    base = acc_cnt;
    first_acc = -1;
    for (int i = 0; i < 20; i++) cyc();
    chk("bp_words_out", acc_cnt - base, 8);
    chk("bp_no_gaps", last_acc - first_acc, 7);
    chk("bp_drained", exq.size(), 0);

    // alternating ready with 16 words
    for (int i = 0; i < 16; i++) load(8'h80 + 8'(i));
    base = acc_cnt;
    for (int i = 0; i < 60; i++) begin
      out_ready = (i % 2 == 0);
      cyc();
    end
    chk("tog_words_out", acc_cnt - base, 16);
    chk("tog_drained", exq.size(), 0);
    chk("tog_idle_valid", int'(out_valid), 0);
    chk("rinc_while_empty", bad_rinc, 0);
    chk("credit_overrun", bad_credit, 0);

    // flush with a word buffered and one in flight
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) load(8'hC0 + 8'(i));
    for (int i = 0; i < 4; i++) cyc();
    chk("fl_level_full", int'(out_level), 2);
    out_ready = 1'b1;
    cyc();
    chk("fl_pre_level", int'(out_level), 1);
    chk("fl_pre_infl", int'(infl_prev), 1);
    out_ready = 1'b0;
    flush = 1'b1;
    #1;
    chk("fl_rinc_blocked", int'(rinc), 0);
    cyc();
    flush = 1'b0;
    void'(exq.pop_front());
    void'(exq.pop_front());
    chk("fl_valid", int'(out_valid), 0);
    chk("fl_level", int'(out_level), 0);
    out_ready = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt == base; i++) cyc();
    chk("fl_next_word", last_word, 8'hC3);
    for (int i = 0; i < 6; i++) cyc();
    chk("fl_drained", exq.size(), 0);

    // reset while holding data
    out_ready = 1'b0;
    load(8'hD0); load(8'hD1); load(8'hD2);
    for (int i = 0; i < 4; i++) cyc();
    chk("rst_pre_valid", int'(out_valid), 1);
    rrst_n = 1'b0;
    #1;
    chk("rst_rinc_now", int'(rinc), 0);
    cyc();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_level", int'(out_level), 0);
    chk("rst_rinc", int'(rinc), 0);
    q.delete();
    exq.delete();
    rempty = 1'b1;
    rrst_n = 1'b1;
    cyc();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
